// File: rtl/pkt_det_axil_regbank_if.sv
// pkt_det_axil_regbank_if: AXI4-Lite bus bundle between the PS interconnect and the detector register bank
interface pkt_det_axil_regbank_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/pkt_det_axil_regbank.sv
// pkt_det_axil_regbank: AXI4-Lite register bank with RW control, RO status and a clear-on-read event counter
// Define PKT_DET_REGBANK_IRQ_EN to add irq_o and its enable register right after the counter.
module pkt_det_axil_regbank #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_CTRL_REGS      = 8,
    parameter int NUM_STAT_REGS      = 4,
    parameter int CNT_WIDTH          = 16
) (
    input  logic                                           S_AXI_ACLK,
    input  logic                                           S_AXI_ARESETN,
    pkt_det_axil_regbank_if.slave                          s_axi,
    output logic [NUM_CTRL_REGS*C_S_AXI_DATA_WIDTH-1:0]    ctrl_o,
    output logic [NUM_CTRL_REGS-1:0]                       ctrl_wr_pulse_o,
    input  logic [NUM_STAT_REGS*C_S_AXI_DATA_WIDTH-1:0]    stat_i,
    input  logic                                           det_event_i
`ifdef PKT_DET_REGBANK_IRQ_EN
    ,
    output logic                                           irq_o
`endif
);
    localparam int DW      = C_S_AXI_DATA_WIDTH;
    localparam int NB      = DW / 8;
    localparam int WS      = (DW == 64) ? 3 : 2;
    localparam int IW      = C_S_AXI_ADDR_WIDTH - WS;
    localparam int CNT_IDX = NUM_CTRL_REGS + NUM_STAT_REGS;
`ifdef PKT_DET_REGBANK_IRQ_EN
    localparam int LAST_IDX = CNT_IDX + 1;
`else
    localparam int LAST_IDX = CNT_IDX;
`endif

    if (DW != 32 && DW != 64) begin : g_bad_dw
        $error("C_S_AXI_DATA_WIDTH must be 32 or 64");
    end
    if (CNT_WIDTH < 1 || CNT_WIDTH > DW) begin : g_bad_cnt
        $error("CNT_WIDTH must be 1..C_S_AXI_DATA_WIDTH");
    end
    if (IW < 1 || LAST_IDX >= (1 << IW)) begin : g_bad_map
        $error("address space too small for all registers");
    end

    logic [DW-1:0]        ctrl [NUM_CTRL_REGS];
    logic [IW-1:0]        aw_idx, ar_idx;
    logic [DW-1:0]        w_data, rd_data;
    logic [NB-1:0]        w_strb;
    logic [1:0]           rd_resp;
    logic                 aw_held, w_held, bvalid, rvalid;
    logic                 aw_hs, w_hs, ar_hs, commit, wr_ok, cnt_clr, irq_en;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
    logic                 unused_ok;

    assign s_axi.awready = !aw_held && !bvalid;
    assign s_axi.wready  = !w_held && !bvalid;
    assign s_axi.arready = !rvalid;
    assign s_axi.bvalid  = bvalid;
    assign s_axi.rvalid  = rvalid;
    assign aw_hs   = s_axi.awvalid && s_axi.awready;
    assign w_hs    = s_axi.wvalid && s_axi.wready;
    assign ar_hs   = s_axi.arvalid && s_axi.arready;
    assign commit  = aw_held && w_held;
    assign wr_ok   = int'(aw_idx) <= LAST_IDX;
    assign ar_idx  = s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:WS];
    assign cnt_clr = ar_hs && int'(ar_idx) == CNT_IDX;
    // a clearing read that coincides with an event leaves that event counted
    assign cnt_nxt = cnt_clr ? CNT_WIDTH'(det_event_i) : cnt + CNT_WIDTH'(det_event_i && cnt != '1);
    assign unused_ok = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[WS-1:0], s_axi.araddr[WS-1:0]};

    for (genvar i = 0; i < NUM_CTRL_REGS; i++) begin : g_ctrl
        assign ctrl_o[i*DW +: DW] = ctrl[i];
    end

    always_comb begin
        rd_data = '0;
        rd_resp = 2'b10;
        for (int k = 0; k < NUM_CTRL_REGS; k++)
            if (int'(ar_idx) == k) begin
                rd_data = ctrl[k];
                rd_resp = 2'b00;
            end
        for (int k = 0; k < NUM_STAT_REGS; k++)
            if (int'(ar_idx) == NUM_CTRL_REGS + k) begin
                rd_data = stat_i[k*DW +: DW];
                rd_resp = 2'b00;
            end
        if (int'(ar_idx) == CNT_IDX) begin
            rd_data = DW'(cnt);
            rd_resp = 2'b00;
        end
`ifdef PKT_DET_REGBANK_IRQ_EN
        if (int'(ar_idx) == CNT_IDX + 1) begin
            rd_data = DW'(irq_en);
            rd_resp = 2'b00;
        end
`endif
    end

    always_ff @(posedge S_AXI_ACLK)
        for (int k = 0; k < NUM_CTRL_REGS; k++) begin
            ctrl_wr_pulse_o[k] <= S_AXI_ARESETN && commit && int'(aw_idx) == k;
            for (int b = 0; b < NB; b++)
                if (!S_AXI_ARESETN) ctrl[k][b*8 +: 8] <= '0;
                else if (commit && int'(aw_idx) == k && w_strb[b]) ctrl[k][b*8 +: 8] <= w_data[b*8 +: 8];
        end

    always_ff @(posedge S_AXI_ACLK)
        if (!S_AXI_ARESETN) begin
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_idx        <= '0;
            w_data        <= '0;
            w_strb        <= '0;
            bvalid        <= 1'b0;
            s_axi.bresp   <= 2'b00;
            rvalid        <= 1'b0;
            s_axi.rdata   <= '0;
            s_axi.rresp   <= 2'b00;
            cnt           <= '0;
            irq_en        <= 1'b0;
        end else begin
            aw_held <= aw_hs ? 1'b1 : commit ? 1'b0 : aw_held;
            w_held  <= w_hs ? 1'b1 : commit ? 1'b0 : w_held;
            if (aw_hs) aw_idx <= s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:WS];
            if (w_hs) begin
                w_data <= s_axi.wdata;
                w_strb <= s_axi.wstrb;
            end
            bvalid <= commit ? 1'b1 : s_axi.bready ? 1'b0 : bvalid;
            if (commit) s_axi.bresp <= wr_ok ? 2'b00 : 2'b10;
            rvalid <= ar_hs ? 1'b1 : s_axi.rready ? 1'b0 : rvalid;
            if (ar_hs) begin
                s_axi.rdata <= rd_data;
                s_axi.rresp <= rd_resp;
            end
            cnt <= cnt_nxt;
`ifdef PKT_DET_REGBANK_IRQ_EN
            if (commit && int'(aw_idx) == CNT_IDX + 1 && w_strb[0]) irq_en <= w_data[0];
`endif
        end

`ifdef PKT_DET_REGBANK_IRQ_EN
    always_ff @(posedge S_AXI_ACLK)
        irq_o <= S_AXI_ARESETN && irq_en && cnt != '0;
`endif
endmodule

// File: tb/tb_pkt_det_axil_regbank.sv
// tb_pkt_det_axil_regbank: directed bench with a cycle-level reference model of the register bank
module tb_pkt_det_axil_regbank;
    localparam int DW      = 32;
    localparam int AW      = 6;
    localparam int NC      = 8;
    localparam int NS      = 4;
    localparam int CW      = 16;
    localparam int CNT_IDX = NC + NS;
    localparam int MAXC    = (1 << CW) - 1;
`ifdef PKT_DET_REGBANK_IRQ_EN
    localparam int HAS_IRQ = 1;
`else
    localparam int HAS_IRQ = 0;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    pkt_det_axil_regbank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    pkt_det_axil_regbank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus4 ();

    logic [NC*DW-1:0] ctrl, ctrl4;
    logic [NC-1:0]    pulse, pulse4;
    logic [NS*DW-1:0] stat;
    logic             det = 1'b0;
    logic             det4 = 1'b0;
`ifdef PKT_DET_REGBANK_IRQ_EN
    logic             irq, irq4;
`endif

    pkt_det_axil_regbank #(.C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW), .NUM_CTRL_REGS(NC),
                           .NUM_STAT_REGS(NS), .CNT_WIDTH(CW)) u_dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rstn), .s_axi(bus), .ctrl_o(ctrl),
        .ctrl_wr_pulse_o(pulse), .stat_i(stat), .det_event_i(det)
`ifdef PKT_DET_REGBANK_IRQ_EN
        , .irq_o(irq)
`endif
    );

    pkt_det_axil_regbank #(.C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW), .NUM_CTRL_REGS(NC),
                           .NUM_STAT_REGS(NS), .CNT_WIDTH(4)) u_dut4 (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rstn), .s_axi(bus4), .ctrl_o(ctrl4),
        .ctrl_wr_pulse_o(pulse4), .stat_i(stat), .det_event_i(det4)
`ifdef PKT_DET_REGBANK_IRQ_EN
        , .irq_o(irq4)
`endif
    );

    int errs = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: register contents and channel state as the bus rules dictate
    logic [31:0]   m_ctrl [NC];
    logic [AW-1:0] m_awa;
    logic [31:0]   m_wd, m_rd;
    logic [3:0]    m_ws;
    logic [1:0]    m_br, m_rr;
    logic [NC-1:0] m_pulse;
    int            m_cnt;
    bit            m_awh, m_wh, m_bv, m_rv, m_irq_en, m_irq;

    function automatic logic [33:0] rd_model(input int idx);
        if (idx < NC) return {2'b00, m_ctrl[idx]};
        if (idx < NC + NS) return {2'b00, stat[(idx-NC)*DW +: DW]};
        if (idx == CNT_IDX) return {2'b00, 32'(m_cnt)};
        if (HAS_IRQ == 1 && idx == CNT_IDX + 1) return {2'b00, 31'd0, m_irq_en};
        return {2'b10, 32'd0};
    endfunction

    initial begin
        bit awr, wr, ar_hs, clr, old_en;
        int old_cnt, idx;
        forever begin
            @(posedge clk);
            if (!rstn) begin
                for (int k = 0; k < NC; k++) m_ctrl[k] = '0;
                {m_awh, m_wh, m_bv, m_rv, m_irq_en, m_irq} = '0;
                m_pulse = '0;
                m_cnt = 0;
                m_rd = '0;
                m_rr = 2'b00;
                m_br = 2'b00;
            end else begin
                awr = !m_awh && !m_bv;
                wr = !m_wh && !m_bv;
                ar_hs = bus.arvalid && !m_rv;
                clr = ar_hs && int'(bus.araddr >> 2) == CNT_IDX;
                old_en = m_irq_en;
                old_cnt = m_cnt;
                m_pulse = '0;
                if (ar_hs) begin
                    {m_rr, m_rd} = rd_model(int'(bus.araddr >> 2));
                    m_rv = 1;
                end else if (m_rv && bus.rready) m_rv = 0;
                if (m_bv && bus.bready) m_bv = 0;
                if (m_awh && m_wh) begin
                    idx = int'(m_awa >> 2);
                    m_br = (idx <= CNT_IDX + HAS_IRQ) ? 2'b00 : 2'b10;
                    if (idx < NC) begin
                        for (int b = 0; b < 4; b++) if (m_ws[b]) m_ctrl[idx][b*8 +: 8] = m_wd[b*8 +: 8];
                        m_pulse[idx] = 1'b1;
                    end
                    if (HAS_IRQ == 1 && idx == CNT_IDX + 1 && m_ws[0]) m_irq_en = m_wd[0];
                    m_bv = 1;
                    m_awh = 0;
                    m_wh = 0;
                end
                if (bus.awvalid && awr) begin
                    m_awh = 1;
                    m_awa = bus.awaddr;
                end
                if (bus.wvalid && wr) begin
                    m_wh = 1;
                    m_wd = bus.wdata;
                    m_ws = bus.wstrb;
                end
                m_cnt = clr ? int'(det) : (det && m_cnt < MAXC) ? m_cnt + 1 : m_cnt;
                m_irq = old_en && old_cnt != 0;
            end
            #2;
            chk("awready", 32'(bus.awready), 32'(!m_awh && !m_bv));
            chk("wready", 32'(bus.wready), 32'(!m_wh && !m_bv));
            chk("arready", 32'(bus.arready), 32'(!m_rv));
            chk("bvalid", 32'(bus.bvalid), 32'(m_bv));
            chk("rvalid", 32'(bus.rvalid), 32'(m_rv));
            chk("wr_pulse", 32'(pulse), 32'(m_pulse));
            if (m_bv) chk("bresp", 32'(bus.bresp), 32'(m_br));
            if (m_rv) begin
                chk("rdata", bus.rdata, m_rd);
                chk("rresp", 32'(bus.rresp), 32'(m_rr));
            end
            for (int k = 0; k < NC; k++) chk($sformatf("ctrl%0d", k), ctrl[k*DW +: DW], m_ctrl[k]);
`ifdef PKT_DET_REGBANK_IRQ_EN
            chk("irq", 32'(irq), 32'(m_irq));
`endif
        end
    end

    task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_delay, output logic [1:0] resp);
        int c;
        bit aw_go, w_go, aw_done, w_done;
        c = 0;
        aw_done = 0;
        w_done = 0;
        @(posedge clk);
        #1;
        bus.awaddr = addr;
        bus.wdata = data;
        bus.wstrb = strb;
        bus.wvalid = 1'b1;
        bus.awvalid = (aw_delay == 0);
        bus.bready = 1'b1;
        while (!(aw_done && w_done) && c < 40) begin
            @(negedge clk);
            aw_go = bus.awvalid && bus.awready;
            w_go = bus.wvalid && bus.wready;
            @(posedge clk);
            #1;
            if (aw_go) begin
                bus.awvalid = 1'b0;
                aw_done = 1;
            end
            if (w_go) begin
                bus.wvalid = 1'b0;
                w_done = 1;
            end
            c++;
            if (c == aw_delay && !aw_done) bus.awvalid = 1'b1;
        end
        c = 0;
        while (!bus.bvalid && c < 40) begin
            @(negedge clk);
            c++;
        end
        chk("bvalid_timeout", 32'(bus.bvalid), 32'd1);
        resp = bus.bresp;
        bus.awvalid = 1'b0;
        bus.wvalid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, input bit ev, output logic [31:0] data,
                            output logic [1:0] resp);
        int c;
        c = 0;
        @(posedge clk);
        #1;
        bus.araddr = addr;
        bus.arvalid = 1'b1;
        bus.rready = 1'b1;
        det = ev;
        do begin
            @(negedge clk);
            c++;
        end while (!bus.arready && c < 40);
        @(posedge clk);
        #1;
        bus.arvalid = 1'b0;
        det = 1'b0;
        c = 0;
        while (!bus.rvalid && c < 40) begin
            @(negedge clk);
            c++;
        end
        chk("rvalid_timeout", 32'(bus.rvalid), 32'd1);
        data = bus.rdata;
        resp = bus.rresp;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_det(input int n);
        repeat (n) begin
            @(posedge clk);
            #1 det = 1'b1;
            @(posedge clk);
            #1 det = 1'b0;
        end
    endtask

    logic [31:0] rd;
    logic [1:0]  rsp;

    initial begin
        {bus.awaddr, bus.awprot, bus.awvalid, bus.wdata, bus.wstrb, bus.wvalid} = '0;
        {bus.araddr, bus.arprot, bus.arvalid} = '0;
        bus.bready = 1'b1;
        bus.rready = 1'b1;
        {bus4.awaddr, bus4.awprot, bus4.awvalid, bus4.wdata, bus4.wstrb, bus4.wvalid} = '0;
        {bus4.araddr, bus4.arprot, bus4.arvalid} = '0;
        bus4.bready = 1'b1;
        bus4.rready = 1'b1;
        stat = {32'h44444444, 32'h33333333, 32'h22222222, 32'hDEADBEEF};
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_ctrl", 32'(|ctrl), 32'd0);

        for (int i = 0; i < 4; i++) begin
            axi_write(6'(i * 4), 32'(i + 1), 4'hF, 0, rsp);
            chk("wr_resp", 32'(rsp), 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(6'(i * 4), 1'b0, rd, rsp);
            chk("rd_back", rd, 32'(i + 1));
            chk("rd_back_resp", 32'(rsp), 32'd0);
        end

        axi_write(6'h04, 32'h11223344, 4'hF, 0, rsp);
        axi_write(6'h04, 32'hAABBCCDD, 4'h5, 3, rsp);
        axi_read(6'h04, 1'b0, rd, rsp);
        chk("strb_merge", rd, 32'h11BB33DD);

        axi_read(6'h20, 1'b0, rd, rsp);
        chk("stat0", rd, 32'hDEADBEEF);
        axi_write(6'h20, 32'h0, 4'hF, 0, rsp);
        chk("stat_wr_resp", 32'(rsp), 32'd0);
        axi_read(6'h20, 1'b0, rd, rsp);
        chk("stat0_kept", rd, 32'hDEADBEEF);
        axi_read(6'h3C, 1'b0, rd, rsp);
        chk("unmapped_rresp", 32'(rsp), 32'd2);
        chk("unmapped_rdata", rd, 32'd0);
        axi_write(6'h3C, 32'h12345678, 4'hF, 0, rsp);
        chk("unmapped_bresp", 32'(rsp), 32'd2);
        axi_read(6'h34, 1'b0, rd, rsp);
        chk("irq_idx_rresp", 32'(rsp), HAS_IRQ == 1 ? 32'd0 : 32'd2);

        pulse_det(5);
        axi_read(6'h30, 1'b0, rd, rsp);
        chk("cnt5", rd, 32'd5);
        axi_read(6'h30, 1'b0, rd, rsp);
        chk("cnt_cleared", rd, 32'd0);
        pulse_det(3);
        axi_read(6'h30, 1'b1, rd, rsp);
        chk("cnt_ev_on_read", rd, 32'd3);
        axi_read(6'h30, 1'b0, rd, rsp);
        chk("cnt_after_ev", rd, 32'd1);

        repeat (20) begin
            @(posedge clk);
            #1 det4 = 1'b1;
            @(posedge clk);
            #1 det4 = 1'b0;
        end
        @(posedge clk);
        #1 bus4.araddr = 6'h30;
        bus4.arvalid = 1'b1;
        @(posedge clk);
        #1 bus4.arvalid = 1'b0;
        @(negedge clk);
        chk("cnt4_rvalid", 32'(bus4.rvalid), 32'd1);
        chk("cnt4_sat", bus4.rdata, 32'd15);

        @(posedge clk);
        #1;
        bus.bready = 1'b0;
        bus.rready = 1'b0;
        bus.awaddr = 6'h08;
        bus.wdata = 32'h5A5A0001;
        bus.wstrb = 4'hF;
        bus.awvalid = 1'b1;
        bus.wvalid = 1'b1;
        bus.araddr = 6'h04;
        bus.arvalid = 1'b1;
        @(posedge clk);
        #1;
        bus.awvalid = 1'b0;
        bus.wvalid = 1'b0;
        bus.arvalid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("stall_bvalid", 32'(bus.bvalid), 32'd1);
        chk("stall_rvalid", 32'(bus.rvalid), 32'd1);
        chk("stall_rdata", bus.rdata, 32'h11BB33DD);
        chk("stall_awready", 32'(bus.awready), 32'd0);
        chk("stall_arready", 32'(bus.arready), 32'd0);
        chk("stall_ctrl2", ctrl[2*DW +: DW], 32'h5A5A0001);
        @(posedge clk);
        #1 rstn = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("mid_rst_bvalid", 32'(bus.bvalid), 32'd0);
        chk("mid_rst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("mid_rst_ctrl", 32'(|ctrl), 32'd0);
        bus.bready = 1'b1;
        bus.rready = 1'b1;
        axi_read(6'h08, 1'b0, rd, rsp);
        chk("post_rst_ctrl2", rd, 32'd0);

`ifdef PKT_DET_REGBANK_IRQ_EN
        axi_write(6'h34, 32'h1, 4'hF, 0, rsp);
        pulse_det(1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("irq_set", 32'(irq), 32'd1);
        axi_read(6'h30, 1'b0, rd, rsp);
        chk("irq_cnt", rd, 32'd1);
        @(negedge clk);
        chk("irq_clr", 32'(irq), 32'd0);
`endif

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
